// File: rtl/fetch_queue_ctrl.sv
// Fetch controller: owns the fetch PC, runs the two-word instruction memory
// handshake and buffers fetched pairs in a circular queue feeding decode.
module fetch_queue_ctrl #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       FQ_DEPTH = 8,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [DATA_W-1:0]         inst_address,
    output logic                      InstMem_Read,
    input  logic                      InstMem_Ready,
    input  logic [DATA_W-1:0]         inst1_in,
    input  logic [DATA_W-1:0]         inst2_in,
    input  logic                      redirect_valid,
    input  logic [DATA_W-1:0]         redirect_pc,
    input  logic [1:0]                deq_count,
    output logic [1:0]                dec_valid,
    output logic [DATA_W-1:0]         dec_inst0,
    output logic [DATA_W-1:0]         dec_inst1,
    output logic [DATA_W-1:0]         dec_pc0,
    output logic [DATA_W-1:0]         dec_pc1,
    output logic [$clog2(FQ_DEPTH):0] fq_count,
    output logic [31:0]               fetched_total
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [DATA_W-1:0] pc;
    } fq_entry_t;

    typedef enum logic {
        ST_STALL = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    fq_entry_t         fq_mem [FQ_DEPTH];
    logic [DATA_W-1:0] pc;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head_nxt1;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [1:0]        deq_eff;
    logic              enq;

    assign inst_address = pc;
    assign fq_count     = count;
    assign head_nxt1    = head + PTR_W'(1);

    // Enqueue qualification, clamped dequeue and resulting occupancy
    always_comb begin
        enq     = (state == ST_FETCH) && InstMem_Ready && !redirect_valid;
        deq_eff = (deq_count > 2'd2) ? 2'd2 : deq_count;
        if (CNT_W'(deq_eff) > count) begin
            deq_eff = count[1:0];
        end
        if (redirect_valid) begin
            deq_eff = 2'd0;
        end
        count_next = count + (enq ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(deq_eff);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_STALL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: keep fetching only while a whole pair still fits afterwards
    always_comb begin
        state_next = ST_STALL;
        if (redirect_valid) begin
            state_next = ST_FETCH;
        end else if ((CNT_W'(FQ_DEPTH) - count_next) >= CNT_W'(2)) begin
            state_next = ST_FETCH;
        end
    end

    // FSM outputs
    always_comb begin
        InstMem_Read = 1'b0;
        if (state == ST_FETCH) begin
            InstMem_Read = 1'b1;
        end
    end

    // PC, pointers, occupancy and fetch counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc            <= RESET_PC;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            fetched_total <= '0;
        end else if (redirect_valid) begin
            pc    <= redirect_pc & ~DATA_W'(3);
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            count <= count_next;
            head  <= head + PTR_W'(deq_eff);
            if (enq) begin
                tail          <= tail + PTR_W'(2);
                pc            <= pc + DATA_W'(8);
                fetched_total <= fetched_total + 32'(2);
            end
        end
    end

    // Queue storage; contents are only observed through valid slots
    always_ff @(posedge clk) begin
        if (enq) begin
            fq_mem[tail]              <= '{inst: inst1_in, pc: pc};
            fq_mem[tail + PTR_W'(1)]  <= '{inst: inst2_in, pc: pc + DATA_W'(4)};
        end
    end

    // Decode view of the two head entries, zeroed when not valid
    always_comb begin
        dec_valid = {count >= CNT_W'(2), count >= CNT_W'(1)};
        dec_inst0 = '0;
        dec_pc0   = '0;
        dec_inst1 = '0;
        dec_pc1   = '0;
        if (dec_valid[0]) begin
            dec_inst0 = fq_mem[head].inst;
            dec_pc0   = fq_mem[head].pc;
        end
        if (dec_valid[1]) begin
            dec_inst1 = fq_mem[head_nxt1].inst;
            dec_pc1   = fq_mem[head_nxt1].pc;
        end
    end

endmodule
